// File: rtl/encoder_pkg.sv
// Shared widths and helpers for the 8-to-3 encoder.
package encoder_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  // Clearing the lowest set bit leaves something behind only if two or more were set.
  function automatic logic popcount_gt1(input logic [IN_W-1:0] v);
    return (v & (v - IN_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/encoder_8x3_core.sv
// Combinational priority encoder: index of the winning set bit plus any/multi flags.
module encoder_8x3_core
  import encoder_pkg::*;
#(
  parameter bit HIGH_PRIORITY = 1'b1
) (
  input  logic [IN_W-1:0]  in,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // The last match in scan order wins, so the scan direction sets the priority.
  always_comb begin
    idx = '0;
    if (HIGH_PRIORITY) begin
      for (int k = 0; k < IN_W; k++) begin
        if (in[k]) idx = IDX_W'(k);
      end
    end else begin
      for (int k = IN_W - 1; k >= 0; k--) begin
        if (in[k]) idx = IDX_W'(k);
      end
    end
  end

  assign any   = |in;
  assign multi = popcount_gt1(in);

endmodule

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 encoder with enable gating and valid/multi-hot status.
module encoder_8x3
  import encoder_pkg::*;
#(
  parameter bit HIGH_PRIORITY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [IDX_W-1:0] o,
  output logic             valid,
  output logic             multi_hot
);

  logic [IN_W-1:0]  in_gated;
  logic [IDX_W-1:0] idx;
  logic             any;
  logic             multi;

  // Gate before the encoder so an undriven request bus cannot leak through while disabled.
  assign in_gated = en ? in : '0;

  encoder_8x3_core #(
    .HIGH_PRIORITY(HIGH_PRIORITY)
  ) u_core (
    .in   (in_gated),
    .idx  (idx),
    .any  (any),
    .multi(multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o         <= '0;
      valid     <= 1'b0;
      multi_hot <= 1'b0;
    end else begin
      o         <= idx;
      valid     <= any;
      multi_hot <= multi;
    end
  end

endmodule

// File: tb/tb_encoder_8x3.sv
// Self-checking bench: both priority settings side by side, table vectors plus reset corners.
module tb_encoder_8x3;

  typedef struct {
    logic [7:0] in;
    logic       en;
    logic [2:0] hi;
    logic [2:0] lo;
    logic       valid;
    logic       multi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in;
  logic       en;
  logic [2:0] o_hi, o_lo;
  logic       valid_hi, valid_lo, multi_hi, multi_lo;

  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  encoder_8x3 #(.HIGH_PRIORITY(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .o(o_hi), .valid(valid_hi), .multi_hot(multi_hi)
  );

  encoder_8x3 #(.HIGH_PRIORITY(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .o(o_lo), .valid(valid_lo), .multi_hot(multi_lo)
  );

  function automatic vec_t mk(input logic [7:0] i, input logic e, input logic [2:0] h,
                              input logic [2:0] l, input logic v, input logic m);
    vec_t r;
    r.in = i; r.en = e; r.hi = h; r.lo = l; r.valid = v; r.multi = m;
    return r;
  endfunction

  // Independent reference: count bits, track first and last set position.
  function automatic vec_t model(input logic [7:0] i, input logic e);
    vec_t r;
    int cnt = 0;
    int first = -1;
    int last = -1;
    if (e) begin
      for (int k = 0; k < 8; k++) begin
        if (i[k]) begin
          cnt++;
          if (first < 0) first = k;
          last = k;
        end
      end
    end
    r.in = i; r.en = e;
    r.valid = (cnt > 0);
    r.multi = (cnt > 1);
    r.hi = (cnt > 0) ? 3'(last) : 3'd0;
    r.lo = (cnt > 0) ? 3'(first) : 3'd0;
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".o_hi"}, o_hi, 0);
    cmp({tag, ".o_lo"}, o_lo, 0);
    cmp({tag, ".valid"}, valid_hi | valid_lo, 0);
    cmp({tag, ".multi"}, multi_hi | multi_lo, 0);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    in = v.in;
    en = v.en;
    exp_q.push_back(v);
  endtask

  task automatic collect(input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      cmp({tag, ".queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".o_hi"}, o_hi, e.hi);
    cmp({tag, ".o_lo"}, o_lo, e.lo);
    cmp({tag, ".valid_hi"}, valid_hi, e.valid);
    cmp({tag, ".valid_lo"}, valid_lo, e.valid);
    cmp({tag, ".multi_hi"}, multi_hi, e.multi);
    cmp({tag, ".multi_lo"}, multi_lo, e.multi);
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    collect(tag);
  endtask

  initial begin
    vec_t r;
    logic [7:0] oh;

    // Disabled sweep, one-hot walk, zero, multi-hot and enable-toggle cases.
    for (int k = 7; k >= 0; k--) begin
      oh = 8'h01 << k;
      tbl.push_back(mk(oh, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    end
    for (int k = 7; k >= 0; k--) begin
      oh = 8'h01 << k;
      tbl.push_back(mk(oh, 1'b1, 3'(k), 3'(k), 1'b1, 1'b0));
    end
    tbl.push_back(mk(8'h00, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(8'b1000_0100, 1'b1, 3'd7, 3'd2, 1'b1, 1'b1));
    tbl.push_back(mk(8'hFF, 1'b1, 3'd7, 3'd0, 1'b1, 1'b1));
    tbl.push_back(mk(8'h18, 1'b1, 3'd4, 3'd3, 1'b1, 1'b1));
    tbl.push_back(mk(8'h81, 1'b1, 3'd7, 3'd0, 1'b1, 1'b1));
    tbl.push_back(mk(8'hFF, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h20, 1'b1, 3'd5, 3'd5, 1'b1, 1'b0));
    tbl.push_back(mk(8'h20, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h03, 1'b1, 3'd1, 3'd0, 1'b1, 1'b1));
    tbl.push_back(mk(8'h40, 1'b1, 3'd6, 3'd6, 1'b1, 1'b0));

    // Load a real result, then assert reset between edges: outputs must clear with no clock.
    rst_n = 1'b1;
    in    = 8'h80;
    en    = 1'b1;
    exp_q.push_back(mk(8'h80, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0));
    collect("first");
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));

    // Disabled with an undriven bus.
    step(mk(8'bxxxx_xxxx, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0), "en0_x");

    // Mid-walk reset pulse: clears at once, then the next edge encodes the unchanged input.
    step(model(8'h08, 1'b1), "walk_pre");
    #1 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    #2 rst_n = 1'b1;
    exp_q.push_back(model(8'h08, 1'b1));
    collect("post_release");
    step(model(8'h04, 1'b1), "walk_post");

    for (int n = 0; n < 40; n++) begin
      r = model(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      step(r, $sformatf("rand[%0d]", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encoder_8x3.md
Name: encoder_8x3

Overview:
- Registered 8-to-3 binary encoder with enable. It converts an 8-bit one-hot request vector into the 3-bit index of the asserted bit.
- Adds priority resolution for multi-hot inputs, plus valid and multi-hot status flags.
- Used wherever a one-hot select or request bus must be compressed to a binary index, such as arbiter grant encoding or interrupt line numbering.

Parameters:
- HIGH_PRIORITY, 1, selects which set bit wins on a multi-hot input: 1 = highest index wins, 0 = lowest index wins.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  8  request vector; bit k set means "index k".
- en  input  1  encoder enable, sampled on clk.
- o  output  3  encoded index of the selected set bit, registered.
- valid  output  1  registered; 1 when o holds a real encoding.
- multi_hot  output  1  registered; 1 when more than one bit of in was set.

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately forces o=3'b000, valid=0 and multi_hot=0, independent of clk.
  - Deassertion is synchronised by the integrator, not inside this block.
  - Reset asserted mid-operation discards any pending result with no residual state.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and are held until the next edge. No handshake; the block accepts new input every cycle.
- en=1, exactly one bit k set:
  - o=k, valid=1, multi_hot=0.
  - Mapping: 8'b0000_0001->0, 8'b0000_0010->1, 8'b0000_0100->2, 8'b0000_1000->3, 8'b0001_0000->4, 8'b0010_0000->5, 8'b0100_0000->6, 8'b1000_0000->7.
- en=1, in=8'h00: o=0, valid=0, multi_hot=0.
- en=1, two or more bits set:
  - valid=1, multi_hot=1.
  - o = index of the highest set bit if HIGH_PRIORITY=1, otherwise the lowest set bit.
- en=0: o=0, valid=0, multi_hot=0 on the next edge, regardless of in. Outputs are cleared, not held.
- en toggling every cycle: each cycle's result depends only on that cycle's en and in. No history or sticky state.
- X/Z on in while en=0 must not propagate to the outputs; the encode logic is gated by en.
- Fully combinational encode path followed by a single register stage. No FSM is required; the block is stateless apart from the output registers.

Decomposition:
- Shared package encoder_pkg:
  - localparams IN_W=8 and IDX_W=3.
  - A function popcount_gt1 used for multi-hot detection.
- One natural sub-module, encoder_8x3_core: purely combinational. It takes in and HIGH_PRIORITY and produces idx[2:0], any and multi.
- The top level adds the en gating and the async-reset output registers.

Test Plan:
- Reset: drive rst_n=0 with in=8'h80, en=1 -> o=0, valid=0, multi_hot=0 immediately, without waiting for a clk edge.
- en=0 phase: en=0 and sweep the one-hot values 8'h80 down to 8'h01, 10 ns each -> o=0, valid=0 throughout.
- en=1 one-hot walk: in = 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01 -> one cycle later o = 7, 6, 5, 4, 3, 2, 1, 0 respectively, with valid=1 and multi_hot=0.
- Zero input: en=1, in=8'h00 -> o=0, valid=0, multi_hot=0.
- Multi-hot: en=1, in=8'b1000_0100 -> o=7 and multi_hot=1 with HIGH_PRIORITY=1; o=2 and multi_hot=1 with HIGH_PRIORITY=0; valid=1 in both cases.
- Mid-stream reset: during the one-hot walk, pulse rst_n low for 3 ns between clock edges -> outputs clear at once, and the first edge after release encodes the then-current in.
